// File: rtl/plic_irq_scheduler_pkg.sv
// Shared types for the PLIC per-context scheduler: id/priority widths,
// sweep FSM states and the per-context best-candidate accumulator.
package types_plic_pkg;

    localparam int PLIC_ID_WIDTH   = 10;
    localparam int PLIC_PRIO_WIDTH = 4;

    typedef enum logic [0:0] {
        SCAN   = 1'b0,
        COMMIT = 1'b1
    } plic_sched_state_t;

    typedef struct packed {
        logic [PLIC_ID_WIDTH-1:0]   best_id;
        logic [PLIC_PRIO_WIDTH-1:0] best_prio;
    } plic_ctx_acc_t;

endpackage

// File: rtl/plic_irq_scheduler_ctx_acc.sv
// One context's sweep accumulator: keeps the highest-priority candidate seen
// this sweep, publishes it with its threshold verdict on commit.
module plic_ctx_acc
    import types_plic_pkg::*;
#(
    parameter int prio_w = PLIC_PRIO_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit,
    input  logic                     cand,
    input  logic [prio_w-1:0]        prio,
    input  logic [prio_w-1:0]        th,
    input  logic [PLIC_ID_WIDTH-1:0] idx,
    input  logic [PLIC_ID_WIDTH-1:0] grant_id,
    output logic [PLIC_ID_WIDTH-1:0] ctx_id,
    output logic                     ctx_irq
);

    plic_ctx_acc_t              acc;
    logic [PLIC_PRIO_WIDTH-1:0] prio_ext;
    logic [PLIC_PRIO_WIDTH-1:0] th_ext;
    logic                       granted_best;
    logic                       granted_pub;

    // prio_w is expected not to exceed PLIC_PRIO_WIDTH (accumulator field width)
    assign prio_ext = PLIC_PRIO_WIDTH'(prio);
    assign th_ext   = PLIC_PRIO_WIDTH'(th);

    assign granted_best = (grant_id != '0) && (acc.best_id == grant_id);
    assign granted_pub  = (grant_id != '0) && (ctx_id == grant_id);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            ctx_id  <= '0;
            ctx_irq <= 1'b0;
        end else if (commit) begin
            acc <= '0;
            // an id granted in this very cycle is already in service: never publish it
            if (granted_best) begin
                ctx_id  <= '0;
                ctx_irq <= 1'b0;
            end else begin
                ctx_id  <= acc.best_id;
                ctx_irq <= (acc.best_id != '0) && (acc.best_prio > th_ext);
            end
        end else begin
            if (cand && (prio_ext > acc.best_prio)) begin
                acc.best_id   <= idx;
                acc.best_prio <= prio_ext;
            end
            if (granted_pub) begin
                ctx_id  <= '0;
                ctx_irq <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/plic_irq_scheduler.sv
// PLIC priority scheduler: sweeps one source per clock for all contexts,
// commits per-context winners and services claim/complete handshakes.
module plic_irq_scheduler
    import types_plic_pkg::*;
#(
    parameter int ctxmax = 9,
    parameter int irqmax = 73,
    parameter int prio_w = PLIC_PRIO_WIDTH
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [irqmax-1:0]                 i_irq_pending,
    input  logic [irqmax*prio_w-1:0]          i_irq_prio,
    input  logic [ctxmax*irqmax-1:0]          i_ctx_ie,
    input  logic [ctxmax*prio_w-1:0]          i_ctx_th,
    input  logic                              i_claim_valid,
    input  logic [3:0]                        i_claim_ctx,
    output logic                              o_claim_ready,
    output logic [PLIC_ID_WIDTH-1:0]          o_claim_id,
    input  logic                              i_complete_valid,
    input  logic [PLIC_ID_WIDTH-1:0]          i_complete_id,
    output logic [ctxmax-1:0]                 o_ctx_irq,
    output logic [ctxmax*PLIC_ID_WIDTH-1:0]   o_ctx_id,
    output logic [irqmax-1:0]                 o_in_service
);

    localparam int IDX_W = (irqmax > 1) ? $clog2(irqmax) : 1;
    localparam logic [PLIC_ID_WIDTH-1:0] IDX_FIRST = PLIC_ID_WIDTH'(1);
    localparam logic [PLIC_ID_WIDTH-1:0] IDX_LAST  = PLIC_ID_WIDTH'(irqmax - 1);

    plic_sched_state_t          state;
    logic [PLIC_ID_WIDTH-1:0]   idx;
    logic [IDX_W-1:0]           idx_sel;
    logic [prio_w-1:0]          prio_arr [irqmax];
    logic [prio_w-1:0]          cur_prio;
    logic                       src_live;
    logic [PLIC_ID_WIDTH-1:0]   claim_ctx_id;
    logic [IDX_W-1:0]           claim_sel;
    logic [PLIC_ID_WIDTH-1:0]   grant_id;
    logic                       complete_ok;
    logic [IDX_W-1:0]           complete_sel;
    logic [irqmax-1:0]          in_service_next;

    always_comb begin
        for (int unsigned s = 0; s < irqmax; s++) begin
            prio_arr[s] = i_irq_prio[s*prio_w +: prio_w];
        end
    end

    // idx never exceeds irqmax-1, so its low bits address every source
    assign idx_sel  = idx[IDX_W-1:0];
    assign cur_prio = prio_arr[idx_sel];
    assign src_live = (state == SCAN) && i_irq_pending[idx_sel] &&
                      !o_in_service[idx_sel] && (cur_prio != '0);

    // out-of-range contexts match no entry and so select id 0
    always_comb begin
        claim_ctx_id = '0;
        for (int unsigned c = 0; c < ctxmax; c++) begin
            if (i_claim_ctx == 4'(c)) begin
                claim_ctx_id = o_ctx_id[c*PLIC_ID_WIDTH +: PLIC_ID_WIDTH];
            end
        end
    end

    assign claim_sel = claim_ctx_id[IDX_W-1:0];
    assign grant_id  = (i_claim_valid && (claim_ctx_id != '0) &&
                        i_irq_pending[claim_sel] && !o_in_service[claim_sel])
                       ? claim_ctx_id : '0;

    assign complete_ok  = i_complete_valid && (i_complete_id != '0) &&
                          (i_complete_id <= IDX_LAST);
    assign complete_sel = i_complete_id[IDX_W-1:0];

    // clear before set: a same-cycle complete and claim of one id leaves it set
    always_comb begin
        in_service_next = o_in_service;
        if (complete_ok) begin
            in_service_next[complete_sel] = 1'b0;
        end
        if (grant_id != '0) begin
            in_service_next[claim_sel] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= SCAN;
            idx           <= IDX_FIRST;
            o_in_service  <= '0;
            o_claim_ready <= 1'b0;
            o_claim_id    <= '0;
        end else begin
            case (state)
                SCAN: begin
                    if (idx == IDX_LAST) begin
                        state <= COMMIT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                COMMIT: begin
                    state <= SCAN;
                    idx   <= IDX_FIRST;
                end
            endcase
            o_in_service  <= in_service_next;
            o_claim_ready <= i_claim_valid;
            o_claim_id    <= grant_id;
        end
    end

    for (genvar c = 0; c < ctxmax; c++) begin : g_ctx
        logic [irqmax-1:0] ie_row;
        assign ie_row = i_ctx_ie[c*irqmax +: irqmax];

        plic_ctx_acc #(
            .prio_w (prio_w)
        ) u_acc (
            .clk      (i_clk),
            .rst      (i_rst),
            .commit   (state == COMMIT),
            .cand     (src_live && ie_row[idx_sel]),
            .prio     (cur_prio),
            .th       (i_ctx_th[c*prio_w +: prio_w]),
            .idx      (idx),
            .grant_id (grant_id),
            .ctx_id   (o_ctx_id[c*PLIC_ID_WIDTH +: PLIC_ID_WIDTH]),
            .ctx_irq  (o_ctx_irq[c])
        );
    end

endmodule

// File: tb/tb_plic_irq_scheduler.sv
// Bench for plic_irq_scheduler: per-cycle comparison against a sweep-snapshot
// model, plus directed scenarios with literal expectations.
module tb_plic_irq_scheduler;

    localparam int CTX = 9;
    localparam int IRQ = 73;
    localparam int PW  = 4;
    localparam int IW  = 10;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [IRQ-1:0]      pend = '0;
    logic [IRQ*PW-1:0]   prio = '0;
    logic [CTX*IRQ-1:0]  ie = '0;
    logic [CTX*PW-1:0]   th = '0;
    logic                claim_valid = 1'b0;
    logic [3:0]          claim_ctx = '0;
    logic                complete_valid = 1'b0;
    logic [IW-1:0]       complete_id = '0;
    logic                claim_ready;
    logic [IW-1:0]       claim_id;
    logic [CTX-1:0]      ctx_irq;
    logic [CTX*IW-1:0]   ctx_id;
    logic [IRQ-1:0]      in_service;

    int n_pass  = 0;
    int n_total = 0;

    plic_irq_scheduler #(
        .ctxmax (CTX),
        .irqmax (IRQ),
        .prio_w (PW)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_irq_pending    (pend),
        .i_irq_prio       (prio),
        .i_ctx_ie         (ie),
        .i_ctx_th         (th),
        .i_claim_valid    (claim_valid),
        .i_claim_ctx      (claim_ctx),
        .o_claim_ready    (claim_ready),
        .o_claim_id       (claim_id),
        .i_complete_valid (complete_valid),
        .i_complete_id    (complete_id),
        .o_ctx_irq        (ctx_irq),
        .o_ctx_id         (ctx_id),
        .o_in_service     (in_service)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic logic [IW-1:0] id_of(int c);
        return ctx_id[c*IW +: IW];
    endfunction

    // Model: each sweep position records what that source looked like when it was
    // visited; the commit picks max priority, then lowest id among those.
    bit m_valid = 1'b0;
    bit m_ins [IRQ];
    int m_id  [CTX];
    bit m_irq [CTX];
    bit m_rdy;
    int m_cid;
    int m_phase;
    bit snap_c [CTX][IRQ];
    int snap_p [IRQ];

    always @(posedge clk) begin
        int g, sel, src, mx, best, thv;
        m_valid = 1'b1;
        if (rst) begin
            for (int s = 0; s < IRQ; s++) begin
                m_ins[s] = 0; snap_p[s] = 0;
                for (int c = 0; c < CTX; c++) snap_c[c][s] = 0;
            end
            for (int c = 0; c < CTX; c++) begin m_id[c] = 0; m_irq[c] = 0; end
            m_rdy = 0; m_cid = 0; m_phase = 0;
        end else begin
            sel = 0;
            if (claim_valid && int'(claim_ctx) < CTX) sel = m_id[claim_ctx];
            g = (claim_valid && sel != 0 && pend[sel] && !m_ins[sel]) ? sel : 0;
            if (m_phase < IRQ - 1) begin
                src = m_phase + 1;
                snap_p[src] = int'(prio[src*PW +: PW]);
                for (int c = 0; c < CTX; c++)
                    snap_c[c][src] = pend[src] && ie[c*IRQ + src] && !m_ins[src] && snap_p[src] != 0;
                for (int c = 0; c < CTX; c++)
                    if (g != 0 && m_id[c] == g) begin m_id[c] = 0; m_irq[c] = 0; end
            end else begin
                for (int c = 0; c < CTX; c++) begin
                    mx = 0;
                    for (int s = 1; s < IRQ; s++)
                        if (snap_c[c][s] && snap_p[s] > mx) mx = snap_p[s];
                    best = 0;
                    if (mx > 0)
                        for (int s = IRQ - 1; s >= 1; s--)
                            if (snap_c[c][s] && snap_p[s] == mx) best = s;
                    thv = int'(th[c*PW +: PW]);
                    if (g != 0 && best == g) begin m_id[c] = 0; m_irq[c] = 0; end
                    else begin m_id[c] = best; m_irq[c] = (best != 0) && (mx > thv); end
                    for (int s = 0; s < IRQ; s++) snap_c[c][s] = 0;
                end
            end
            if (complete_valid && complete_id != 0 && int'(complete_id) < IRQ) m_ins[complete_id] = 0;
            if (g != 0) m_ins[g] = 1;
            m_rdy = claim_valid;
            m_cid = g;
            m_phase = (m_phase == IRQ - 1) ? 0 : m_phase + 1;
        end
    end

    always @(negedge clk) begin
        logic [CTX*IW-1:0] e_id;
        logic [CTX-1:0]    e_irq;
        logic [IRQ-1:0]    e_ins;
        if (m_valid) begin
            for (int c = 0; c < CTX; c++) begin
                e_id[c*IW +: IW] = IW'(m_id[c]);
                e_irq[c] = m_irq[c];
            end
            for (int s = 0; s < IRQ; s++) e_ins[s] = m_ins[s];
            chk("model_ctx_irq", 128'(ctx_irq), 128'(e_irq));
            chk("model_ctx_id", 128'(ctx_id), 128'(e_id));
            chk("model_in_service", 128'(in_service), 128'(e_ins));
            chk("model_claim_ready", 128'(claim_ready), 128'(m_rdy));
            chk("model_claim_id", 128'(claim_id), 128'(m_cid));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic src(int s, int p);
        pend[s] = 1'b1;
        prio[s*PW +: PW] = PW'(p);
    endtask

    task automatic en(int c, int s);
        ie[c*IRQ + s] = 1'b1;
    endtask

    task automatic set_th(int c, int v);
        th[c*PW +: PW] = PW'(v);
    endtask

    initial begin
        repeat (3) step();
        chk("reset_ctx_irq", 128'(ctx_irq), 128'(0));
        chk("reset_ctx_id", 128'(ctx_id), 128'(0));
        chk("reset_in_service", 128'(in_service), 128'(0));
        chk("reset_claim_ready", 128'(claim_ready), 128'(0));
        rst = 1'b0;

        repeat (200) step();
        chk("idle_ctx_irq", 128'(ctx_irq), 128'(0));
        chk("idle_ctx_id", 128'(ctx_id), 128'(0));
        claim_valid = 1'b1; claim_ctx = 4'd0;
        step();
        chk("idle_claim_ready", 128'(claim_ready), 128'(1));
        chk("idle_claim_id", 128'(claim_id), 128'(0));
        claim_valid = 1'b0;
        step();
        chk("claim_ready_one_cycle", 128'(claim_ready), 128'(0));

        src(5, 3); src(9, 3); en(0, 5); en(0, 9); set_th(0, 0);
        repeat (2*IRQ) step();
        chk("tie_lowest_id", 128'(id_of(0)), 128'(5));
        chk("tie_irq", 128'(ctx_irq[0]), 128'(1));

        src(40, 7); en(0, 40); set_th(0, 6);
        repeat (2*IRQ) step();
        chk("higher_prio_id", 128'(id_of(0)), 128'(40));
        chk("higher_prio_irq", 128'(ctx_irq[0]), 128'(1));
        set_th(0, 7);
        repeat (2*IRQ) step();
        chk("th_equal_id", 128'(id_of(0)), 128'(40));
        chk("th_equal_irq", 128'(ctx_irq[0]), 128'(0));

        pend = '0; set_th(0, 0); set_th(3, 0);
        src(12, 2); en(0, 12); en(3, 12);
        repeat (2*IRQ) step();
        chk("shared_id_ctx0", 128'(id_of(0)), 128'(12));
        chk("shared_id_ctx3", 128'(id_of(3)), 128'(12));
        claim_valid = 1'b1; claim_ctx = 4'd0;
        step();
        chk("claim12_id", 128'(claim_id), 128'(12));
        chk("claim12_in_service", 128'(in_service[12]), 128'(1));
        chk("claim12_irq_drop", 128'({ctx_irq[3], ctx_irq[0]}), 128'(0));
        claim_ctx = 4'd3;
        step();
        chk("claim_ctx3_after", 128'(claim_id), 128'(0));
        claim_valid = 1'b0;

        complete_valid = 1'b1; complete_id = 10'd12;
        step();
        complete_valid = 1'b0;
        chk("complete12", 128'(in_service[12]), 128'(0));
        repeat (2*IRQ) step();
        chk("reassert_id0", 128'(id_of(0)), 128'(12));
        chk("reassert_id3", 128'(id_of(3)), 128'(12));
        chk("reassert_irq", 128'({ctx_irq[3], ctx_irq[0]}), 128'(3));
        claim_valid = 1'b1; claim_ctx = 4'd0;
        complete_valid = 1'b1; complete_id = 10'd12;
        step();
        chk("same_cycle_claim_id", 128'(claim_id), 128'(12));
        chk("same_cycle_in_service", 128'(in_service[12]), 128'(1));
        complete_valid = 1'b0;

        claim_ctx = 4'd9;
        step();
        claim_valid = 1'b0;
        chk("claim_ctx9_ready", 128'(claim_ready), 128'(1));
        chk("claim_ctx9_id", 128'(claim_id), 128'(0));
        complete_valid = 1'b1; complete_id = 10'd0;
        step();
        chk("complete_id0", 128'(in_service), 128'(1) << 12);
        complete_id = 10'd80;
        step();
        complete_valid = 1'b0;
        chk("complete_id80", 128'(in_service), 128'(1) << 12);

        src(72, 1); en(8, 72); set_th(8, 0);
        repeat (2*IRQ) step();
        chk("last_src_id", 128'(id_of(8)), 128'(72));
        chk("last_src_irq", 128'(ctx_irq[8]), 128'(1));
        claim_valid = 1'b1; claim_ctx = 4'd8;
        step();
        claim_valid = 1'b0;
        chk("last_src_claim", 128'(claim_id), 128'(72));

        repeat (30) step();
        rst = 1'b1;
        step();
        chk("midsweep_rst_irq", 128'(ctx_irq), 128'(0));
        chk("midsweep_rst_id", 128'(ctx_id), 128'(0));
        chk("midsweep_rst_ins", 128'(in_service), 128'(0));
        chk("midsweep_rst_claim", 128'({claim_ready, claim_id}), 128'(0));
        rst = 1'b0;
        repeat (2*IRQ) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
